dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: port 0 is the CPU load/store path and port 1 is the auxiliary master (debug/DMA).
- Round-robin arbitration with a combinational same-cycle grant.
- Two-stage pipeline: issue register, then read-return register.
- Sits between the I/O address decode and the data-memory controller. Replaces the direct CPU-to-memory connection.

Parameters:
- DBITS, 32, data and address width.
- DMEMADDRBITS, 13, byte-address bits covering data memory.
- DMEMWORDBITS, 2, byte-offset bits within a word.
- DMEMWORDS, 2048, memory depth in words.
- DMEM_BASE, 32'h0, byte address of word 0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- r0_req  in  1  port 0 access request
- r0_we  in  1  port 0 write (1) / read (0)
- r0_addr  in  DBITS  port 0 byte address
- r0_wdata  in  DBITS  port 0 write data
- r0_gnt  out  1  port 0 request accepted this cycle
- r0_rvalid  out  1  port 0 read data valid (one-cycle pulse)
- r0_rdata  out  DBITS  port 0 read data
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as port 0, for port 1
- mem_wrtEn  out  1  memory write enable
- mem_index  out  DMEMADDRBITS-DMEMWORDBITS  memory word index
- mem_dataIn  out  DBITS  memory write data
- mem_dataOut  in  DBITS  memory read data, valid one cycle after mem_index
- err  out  1  range-error pulse (optional feature only; otherwise tied 0)

Behaviour:
- Clock and reset: single clock domain, clk, rising edge. reset is asynchronous, active-high, and acts on every register.
- Reset values:
  - last_pt = 1, so port 0 wins the first contention.
  - iss_valid = 0, rd_valid = 0.
  - r0_rdata = r1_rdata = 0; rvalid = 0, mem_wrtEn = 0, err = 0.
- Handshake: a requester holds req, we, addr and wdata stable until it sees gnt high; transfer occurs on req & gnt at the clock edge. The gnt outputs are combinational from req and last_pt.
- Arbitration:
  - Only one requester active: it is granted.
  - Both active: grant goes to the port != last_pt.
  - last_pt updates to the granted id on each grant.
  - At most one grant per cycle; worst-case wait is 1 cycle.
- Cycle N (grant): the issue register loads valid, id, we, index and wdata.
  - index = (addr - DMEM_BASE) >> DMEMWORDBITS, truncated to the mem_index width.
- Cycle N+1 (issue):
  - mem_index and mem_dataIn are driven from the issue register.
  - mem_wrtEn = iss_valid & iss_we.
  - Reads: rd_valid and rd_id are registered.
- Cycle N+2 (return): rK_rvalid pulses high for exactly 1 cycle for a read by port K. In the same cycle rK_rdata takes mem_dataOut.
  - rK_rdata is held until the next read return to port K.
- Writes produce no rvalid. A write is complete at its issue edge.
- Throughput: one access per cycle, sustained. Back-to-back grants alternate ports under contention.
- Ordering: memory order equals grant order. A read granted the cycle after a write to the same word returns the new data.
- Idle cycles: when neither port requests, iss_valid = 0 next cycle and mem_wrtEn = 0. mem_index holds its previous value.
- Reset mid-operation: in-flight issue and return stages are discarded with no rvalid, and last_pt returns to 1. A write already presented to memory in the reset cycle is not guaranteed.

Optional Feature:
- Macro: DMEM_ARB_RANGE_CHECK_EN.
- Enabled:
  - A granted request is an error if addr < DMEM_BASE, addr >= DMEM_BASE + DMEMWORDS*4, or addr[DMEMWORDBITS-1:0] != 0.
  - An error request is granted normally but never reaches memory: mem_wrtEn stays 0.
  - err pulses in cycle N+1.
  - An error read still returns rvalid at N+2, with rdata = 0.
- Disabled: no check; out-of-range addresses wrap modulo DMEMWORDS; err is constant 0.

Test Plan:
- Port 0 only: write 32'hDEADBEEF to addr 32'h100, then read 32'h100 -> mem_wrtEn=1 with mem_index=64 one cycle after the write grant; r0_rvalid exactly 2 cycles after the read grant with r0_rdata=32'hDEADBEEF.
- Both ports request reads every cycle for 6 cycles, from addrs 32'h0 and 32'h4 -> first grant to port 0, then grants alternate 0,1,0,1,0,1; each rvalid lands at grant+2 with the matching data.
- Port 1 writes 32'h12345678 to 32'h20 in cycle N; port 0 reads 32'h20 in cycle N+1 -> r0_rdata=32'h12345678.
- Read granted, then reset asserted asynchronously the next cycle -> no rvalid ever appears. After release, simultaneous requests grant port 0 first.
- With DMEM_ARB_RANGE_CHECK_EN: port 0 reads 32'h2000 -> err pulse at N+1, mem_wrtEn=0, r0_rvalid at N+2 with rdata=0. A write to 32'h102 -> err pulse, memory unchanged.
- Without the macro: a write to 32'h2000 -> mem_index=0 (wrap), err stays 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the
// single-port synchronous data memory.
interface dmem_arbiter_if #(
   parameter int DBITS   = 32,
   parameter int IDXBITS = 11
);
   logic             r0_req, r0_we, r0_gnt, r0_rvalid;
   logic [DBITS-1:0] r0_addr, r0_wdata, r0_rdata;
   logic             r1_req, r1_we, r1_gnt, r1_rvalid;
   logic [DBITS-1:0] r1_addr, r1_wdata, r1_rdata;
   logic               mem_wrtEn;
   logic [IDXBITS-1:0] mem_index;
   logic [DBITS-1:0]   mem_dataIn, mem_dataOut;
   logic               err;

   // Arbiter view.
   modport slave (
      input  r0_req, r0_we, r0_addr, r0_wdata,
      output r0_gnt, r0_rvalid, r0_rdata,
      input  r1_req, r1_we, r1_addr, r1_wdata,
      output r1_gnt, r1_rvalid, r1_rdata,
      output mem_wrtEn, mem_index, mem_dataIn,
      input  mem_dataOut,
      output err
   );

   // Environment view: requesters plus the memory.
   modport master (
      output r0_req, r0_we, r0_addr, r0_wdata,
      input  r0_gnt, r0_rvalid, r0_rdata,
      output r1_req, r1_we, r1_addr, r1_wdata,
      input  r1_gnt, r1_rvalid, r1_rdata,
      input  mem_wrtEn, mem_index, mem_dataIn,
      output mem_dataOut,
      input  err
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory; grant -> issue -> return.
// Define DMEM_ARB_RANGE_CHECK_EN to flag out-of-range/misaligned accesses on err.
module dmem_arbiter #(
   parameter int               DBITS        = 32,
   parameter int               DMEMADDRBITS = 13,
   parameter int               DMEMWORDBITS = 2,
   parameter int               DMEMWORDS    = 2048,
   parameter logic [DBITS-1:0] DMEM_BASE    = '0
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);
   localparam int IDXBITS = DMEMADDRBITS - DMEMWORDBITS;
   localparam int NPORTS  = 2;

   logic [NPORTS-1:0]            req, we, gnt, rvalid;
   logic [NPORTS-1:0][DBITS-1:0] addr, wdata, rdata;

   assign req   = {bus.r1_req, bus.r0_req};
   assign we    = {bus.r1_we, bus.r0_we};
   assign addr  = {bus.r1_addr, bus.r0_addr};
   assign wdata = {bus.r1_wdata, bus.r0_wdata};

   assign bus.r0_gnt    = gnt[0];
   assign bus.r1_gnt    = gnt[1];
   assign bus.r0_rvalid = rvalid[0];
   assign bus.r1_rvalid = rvalid[1];
   assign bus.r0_rdata  = rdata[0];
   assign bus.r1_rdata  = rdata[1];

   logic lastPt;

   // Contention goes to the port that did not win last; a lone requester always wins.
   always_comb begin
      gnt = '0;
      if (req[0] && (!req[1] || lastPt)) gnt[0] = 1'b1;
      else if (req[1])                   gnt[1] = 1'b1;
   end

   logic               selId, selErr;
   logic [DBITS-1:0]   selAddr;
   logic [IDXBITS-1:0] selIndex;

   assign selId    = gnt[1];
   assign selAddr  = addr[selId];
   assign selIndex = IDXBITS'((selAddr - DMEM_BASE) >> DMEMWORDBITS);

`ifdef DMEM_ARB_RANGE_CHECK_EN
   localparam logic [DBITS:0] LIMIT = {1'b0, DMEM_BASE} + (DBITS+1)'(DMEMWORDS * 4);
   assign selErr = (selAddr < DMEM_BASE) || ({1'b0, selAddr} >= LIMIT) ||
                   (selAddr[DMEMWORDBITS-1:0] != '0);
`else
   assign selErr = 1'b0;
`endif

   // vldPipe[0]: issue stage holds an access; vldPipe[1]: a read is returning.
   logic [1:0]         vldPipe;
   logic               issId, issWe, issErr, rdId, rdErr;
   logic [IDXBITS-1:0] issIndex;
   logic [DBITS-1:0]   issWdata, retData;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lastPt   <= 1'b1;
         vldPipe  <= '0;
         issId    <= 1'b0;
         issWe    <= 1'b0;
         issErr   <= 1'b0;
         issIndex <= '0;
         issWdata <= '0;
         rdId     <= 1'b0;
         rdErr    <= 1'b0;
      end else begin
         vldPipe[0] <= |gnt;
         vldPipe[1] <= vldPipe[0] & ~issWe;
         // Index/data only load on a grant so mem_index holds across idle cycles.
         if (|gnt) begin
            lastPt   <= selId;
            issId    <= selId;
            issWe    <= we[selId];
            issErr   <= selErr;
            issIndex <= selIndex;
            issWdata <= wdata[selId];
         end
         if (vldPipe[0]) begin
            rdId  <= issId;
            rdErr <= issErr;
         end
      end
   end

   assign bus.mem_wrtEn  = vldPipe[0] & issWe & ~issErr;
   assign bus.mem_index  = issIndex;
   assign bus.mem_dataIn = issWdata;
`ifdef DMEM_ARB_RANGE_CHECK_EN
   assign bus.err = vldPipe[0] & issErr;
`else
   assign bus.err = 1'b0;
`endif

   assign retData = rdErr ? '0 : bus.mem_dataOut;

   // Return data is passed straight through on the rvalid cycle, then held.
   for (genvar k = 0; k < NPORTS; k++) begin : gRet
      logic [DBITS-1:0] held;
      assign rvalid[k] = vldPipe[1] & (rdId == 1'(k));
      assign rdata[k]  = rvalid[k] ? retData : held;
      always_ff @(posedge clk or posedge reset) begin
         if (reset)          held <= '0;
         else if (rvalid[k]) held <= retData;
      end
   end
endmodule
